// File: rtl/spi_link_pkg.sv
// Frame definition for the register-access link.
// Shared by the SPI host master and the miner-side SPI slave.
package spi_link_pkg;

    localparam int FRAME_BITS    = 16;
    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_W        = 7;
    localparam int DATA_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    // Byte 0 is {write, addr}. Byte 1 carries the write data, or zeros for a read.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic              write,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] cmd_byte;
        logic [DATA_W-1:0] data_byte;
        cmd_byte                = '0;
        cmd_byte[ADDR_W-1:0]    = addr;
        cmd_byte[CMD_WRITE_BIT] = write;
        data_byte               = write ? wdata : '0;
        return {cmd_byte, data_byte};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator for the SPI host master.
// While enabled, SCLK alternates between HALF_PERIOD clocks low and HALF_PERIOD
// clocks high, starting with the low phase. The strobes flag the last clock of
// each phase, so the edge that follows is the SCLK transition.
module spi_sclk_gen #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_next,
    output logic fall_next
);

    localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);

    logic [7:0] phase_cnt_reg;
    logic       sclk_reg;
    logic       phase_end;

    assign phase_end = en && (phase_cnt_reg == 8'd0);
    assign rise_next = phase_end && !sclk_reg;
    assign fall_next = phase_end && sclk_reg;
    assign sclk      = sclk_reg;

    // Phase down-counter: reload at each phase boundary, park low and reloaded when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt_reg <= PHASE_LAST;
            sclk_reg      <= 1'b0;
        end else if (!en) begin
            phase_cnt_reg <= PHASE_LAST;
            sclk_reg      <= 1'b0;
        end else if (phase_cnt_reg == 8'd0) begin
            phase_cnt_reg <= PHASE_LAST;
            sclk_reg      <= ~sclk_reg;
        end else begin
            phase_cnt_reg <= phase_cnt_reg - 8'd1;
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 host master.
// Sends one 16-bit register-access frame per request and returns the byte
// captured on MISO during the data byte. It also synchronises the client IRQ line.
module spi_host_master
    import spi_link_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int CS_GAP      = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              SCSN_toClient,
    output logic              SCLK_toClient,
    output logic              MOSI_toClient,
    input  logic              MISO_fromClient,
    input  logic              IRQ_OUT_fromClient,
    output logic              irq_sync
);

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);
    localparam logic [3:0] BIT_FIRST  = 4'(FRAME_BITS - 1);
    localparam logic [3:0] DATA_BITS  = 4'(DATA_W);

    spi_state_e            state_reg;
    logic [7:0]            timer_reg;
    logic [3:0]            bit_cnt_reg;
    logic                  final_bit_reg;
    logic [FRAME_BITS-1:0] tx_reg;
    logic [DATA_W-1:0]     rx_reg;
    logic                  scsn_reg;
    logic                  mosi_reg;
    logic                  busy_reg;
    logic                  req_ready_reg;
    logic                  rsp_valid_reg;
    logic [DATA_W-1:0]     rsp_rdata_reg;
    logic [1:0]            irq_pipe_reg;

    logic                  shift_en;
    logic                  sclk_rise_next;
    logic                  sclk_fall_next;
    logic [FRAME_BITS-1:0] req_frame;

    assign req_frame = build_frame(req_write, req_addr, req_wdata);
    assign shift_en  = (state_reg == ST_SHIFT);

    spi_sclk_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sclk_gen (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .en        (shift_en),
        .sclk      (SCLK_toClient),
        .rise_next (sclk_rise_next),
        .fall_next (sclk_fall_next)
    );

    // Frame sequencer: chip-select timing, MOSI shifting, MISO capture and the response.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= 8'd0;
            bit_cnt_reg   <= 4'd0;
            final_bit_reg <= 1'b0;
            tx_reg        <= '0;
            rx_reg        <= '0;
            scsn_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        tx_reg        <= req_frame;
                        mosi_reg      <= req_frame[FRAME_BITS-1];
                        bit_cnt_reg   <= BIT_FIRST;
                        final_bit_reg <= 1'b0;
                        scsn_reg      <= 1'b0;
                        busy_reg      <= 1'b1;
                        req_ready_reg <= 1'b0;
                        timer_reg     <= SETUP_LAST;
                        state_reg     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer_reg == 8'd0) begin
                        state_reg <= ST_SHIFT;
                    end else begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
                ST_SHIFT: begin
                    // Mark the final bit at its rising edge.
                    // The closing falling edge then leaves SHIFT on a single flag.
                    if (sclk_rise_next) begin
                        final_bit_reg <= (bit_cnt_reg == 4'd0);
                    end
                    if (sclk_fall_next) begin
                        // MISO is stable for the whole high phase, so sample it on the last high clock.
                        if (bit_cnt_reg < DATA_BITS) begin
                            rx_reg <= {rx_reg[DATA_W-2:0], MISO_fromClient};
                        end
                        if (final_bit_reg) begin
                            timer_reg <= HOLD_LAST;
                            state_reg <= ST_HOLD;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 4'd1;
                            mosi_reg    <= tx_reg[bit_cnt_reg - 4'd1];
                        end
                    end
                end
                ST_HOLD: begin
                    if (timer_reg == 8'd0) begin
                        scsn_reg      <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= rx_reg;
                        timer_reg     <= GAP_LAST;
                        state_reg     <= ST_GAP;
                    end else begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (timer_reg == 8'd0) begin
                        busy_reg      <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous client interrupt. It runs independently of the FSM.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_pipe_reg <= 2'b00;
        end else begin
            irq_pipe_reg <= {irq_pipe_reg[0], IRQ_OUT_fromClient};
        end
    end

    assign req_ready     = req_ready_reg;
    assign busy          = busy_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign SCSN_toClient = scsn_reg;
    assign MOSI_toClient = mosi_reg;
    assign irq_sync      = irq_pipe_reg[1];

endmodule

// File: tb/tb_spi_host_master.sv
// Testbench for spi_host_master.
// Two instances are used: one with the default timing and one with the fastest
// timing. A select line routes the shared stimulus to one instance and muxes its
// outputs back. A behavioural slave and a frame-level model set the expected values.
module tb_spi_host_master;

    localparam int A_HP = 4, A_SETUP = 2, A_HOLD = 2, A_GAP = 4;
    localparam int B_HP = 2, B_SETUP = 1, B_HOLD = 1, B_GAP = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       req_valid, req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       miso, irq;

    logic       rdy_a, rspv_a, busy_a, scsn_a, sclk_a, mosi_a, irqs_a;
    logic       rdy_b, rspv_b, busy_b, scsn_b, sclk_b, mosi_b, irqs_b;
    logic [7:0] rd_a, rd_b;
    logic       valid_a, valid_b;

    logic       req_ready, rsp_valid, busy, scsn, sclk, mosi, irq_sync;
    logic [7:0] rsp_rdata;

    always #5 clk = ~clk;

    assign valid_a = req_valid & ~sel;
    assign valid_b = req_valid & sel;

    spi_host_master #(.HALF_PERIOD(A_HP), .CS_SETUP(A_SETUP), .CS_HOLD(A_HOLD), .CS_GAP(A_GAP)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .req_valid(valid_a), .req_ready(rdy_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_a), .rsp_rdata(rd_a), .busy(busy_a),
        .SCSN_toClient(scsn_a), .SCLK_toClient(sclk_a), .MOSI_toClient(mosi_a),
        .MISO_fromClient(miso), .IRQ_OUT_fromClient(irq), .irq_sync(irqs_a));

    spi_host_master #(.HALF_PERIOD(B_HP), .CS_SETUP(B_SETUP), .CS_HOLD(B_HOLD), .CS_GAP(B_GAP)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .req_valid(valid_b), .req_ready(rdy_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_b), .rsp_rdata(rd_b), .busy(busy_b),
        .SCSN_toClient(scsn_b), .SCLK_toClient(sclk_b), .MOSI_toClient(mosi_b),
        .MISO_fromClient(miso), .IRQ_OUT_fromClient(irq), .irq_sync(irqs_b));

    assign req_ready = sel ? rdy_b  : rdy_a;
    assign rsp_valid = sel ? rspv_b : rspv_a;
    assign rsp_rdata = sel ? rd_b   : rd_a;
    assign busy      = sel ? busy_b : busy_a;
    assign scsn      = sel ? scsn_b : scsn_a;
    assign sclk      = sel ? sclk_b : sclk_a;
    assign mosi      = sel ? mosi_b : mosi_a;
    assign irq_sync  = sel ? irqs_b : irqs_a;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Timing model of the currently selected instance.
    int hp, cs_s, cs_h, cs_g;
    bit loopback;
    logic [7:0] last_rdata;

    // Pending requests plus the bytes the slave returns on MISO.
    bit         q_w[$];
    logic [6:0] q_a[$];
    logic [7:0] q_d[$];
    logic [7:0] q_junk[$];
    logic [7:0] q_rd[$];
    int         acc_t[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_mode(input bit s);
        sel  = s;
        hp   = s ? B_HP    : A_HP;
        cs_s = s ? B_SETUP : A_SETUP;
        cs_h = s ? B_HOLD  : A_HOLD;
        cs_g = s ? B_GAP   : A_GAP;
    endtask

    task automatic add_req(input bit w, input logic [6:0] a, input logic [7:0] d,
                           input logic [7:0] junk, input logic [7:0] rd);
        q_w.push_back(w); q_a.push_back(a); q_d.push_back(d);
        q_junk.push_back(junk); q_rd.push_back(rd);
    endtask

    task automatic drive_reqs(input int n, input bit b2b);
        for (int i = 0; i < n; i++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            req_valid = 1'b1;
            req_write = q_w[i];
            req_addr  = q_a[i];
            req_wdata = q_d[i];
            while (!req_ready && waited < 3000) begin
                @(negedge clk);
                waited++;
            end
            if (!req_ready) begin
                check_eq("accept_timeout", 0, 1);
                req_valid = 1'b0;
                return;
            end
            acc_t.push_back(cyc);
            @(posedge clk);
            if (!b2b || i == n - 1) begin
                // Scramble the request fields after accept. The frame in flight must ignore them.
                @(negedge clk);
                req_valid = 1'b0;
                req_write = 1'($urandom);
                req_addr  = 7'($urandom);
                req_wdata = 8'($urandom);
            end
        end
    endtask

    task automatic monitor_frames(input int n);
        int high;
        int bad_gap;
        high    = 0;
        bad_gap = 0;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            int t, low, rises, falls, bad_mosi, bad_hs, early_rsp, r1, r2;
            logic [15:0] stream, mosi_word, exp_mosi;
            logic [7:0] exp_rd;
            logic prev_sclk, prev_mosi;
            t = 0;
            while (scsn && t < 3000) begin
                high++;
                if (k > 0 && high <= cs_g && (req_ready || !busy)) bad_gap++;
                @(negedge clk);
                t++;
            end
            if (scsn) begin
                check_eq("frame_start_timeout", 0, 1);
                return;
            end
            if (k > 0) begin
                check_eq("cs_high_time", high, cs_g + 1);
                check_eq("gap_handshake", bad_gap, 0);
            end
            exp_mosi  = {q_w[k], q_a[k], (q_w[k] ? q_d[k] : 8'h00)};
            exp_rd    = loopback ? (q_w[k] ? q_d[k] : 8'h00) : q_rd[k];
            stream    = {q_junk[k], q_rd[k]};
            mosi_word = 16'h0000;
            low = 0; rises = 0; falls = 0; bad_mosi = 0; bad_hs = 0; early_rsp = 0;
            r1 = -1; r2 = -1;
            prev_sclk = sclk;
            prev_mosi = mosi;
            if (!loopback) miso = stream[15];
            while (!scsn && low < 3000) begin
                low++;
                if (req_ready || !busy) bad_hs++;
                if (rsp_valid) early_rsp++;
                if (low > 1 && mosi !== prev_mosi && !(prev_sclk && !sclk)) bad_mosi++;
                if (sclk && !prev_sclk) begin
                    rises++;
                    mosi_word = {mosi_word[14:0], mosi};
                    if (r1 < 0) r1 = cyc;
                    else if (r2 < 0) r2 = cyc;
                    if (loopback) miso = mosi;
                end
                if (!sclk && prev_sclk) begin
                    falls++;
                    if (!loopback && falls < 16) miso = stream[15 - falls];
                end
                prev_sclk = sclk;
                prev_mosi = mosi;
                @(negedge clk);
            end
            if (!scsn) begin
                check_eq("frame_end_timeout", 0, 1);
                return;
            end
            // Now in the first clock with SCSN high again.
            check_eq("rsp_valid", rsp_valid, 1);
            check_eq("rsp_rdata", rsp_rdata, exp_rd);
            check_eq("mosi_word", mosi_word, exp_mosi);
            check_eq("sclk_rises", rises, 16);
            check_eq("sclk_low_at_end", sclk, 0);
            check_eq("cs_low_time", low, cs_s + 32 * hp + cs_h);
            check_eq("sclk_period", r2 - r1, 2 * hp);
            check_eq("mosi_stability", bad_mosi, 0);
            check_eq("busy_ready_in_frame", bad_hs, 0);
            check_eq("no_early_rsp", early_rsp, 0);
            check_eq("busy_at_rsp", {busy, req_ready}, 2'b10);
            if (acc_t.size() > k) check_eq("latency", cyc - acc_t[k], 1 + cs_s + 32 * hp + cs_h);
            else check_eq("accept_recorded", acc_t.size(), k + 1);
            $display("frame sel=%0d %s a=%02h mosi=%04h rdata=%02h lat=%0d",
                     sel, q_w[k] ? "WR" : "RD", q_a[k], mosi_word, rsp_rdata,
                     (acc_t.size() > k) ? cyc - acc_t[k] : -1);
            last_rdata = exp_rd;
            @(negedge clk);
            check_eq("rsp_pulse_width", rsp_valid, 0);
            high    = 1;
            bad_gap = 0;
        end
    endtask

    task automatic run_frames(input int n, input bit b2b);
        acc_t.delete();
        fork
            drive_reqs(n, b2b);
            monitor_frames(n);
        join
        repeat (3) @(negedge clk);
        check_eq("rdata_hold", rsp_rdata, last_rdata);
        q_w.delete(); q_a.delete(); q_d.delete(); q_junk.delete(); q_rd.delete();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, t, t0, first_irq, irq_cnt, rsp_seen;
        logic prev;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        miso = 1'b0; irq = 1'b0; loopback = 1'b0; last_rdata = 8'h00;
        rst_n = 1'b0;
        set_mode(1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Idle state of both instances after reset.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_eq("rst_scsn", scsn, 1);
            check_eq("rst_sclk", sclk, 0);
            check_eq("rst_mosi", mosi, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_rdata", rsp_rdata, 8'h00);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_req_ready", req_ready, 1);
            check_eq("rst_irq_sync", irq_sync, 0);
        end
        set_mode(1'b0);

        // Directed write, then directed read with junk on MISO during byte 0.
        add_req(1'b1, 7'h12, 8'hA5, 8'($urandom), 8'($urandom));
        run_frames(1, 1'b0);
        add_req(1'b0, 7'h05, 8'($urandom), 8'($urandom), 8'h3C);
        run_frames(1, 1'b0);

        // Three requests with req_valid held high throughout.
        for (int i = 0; i < 3; i++)
            add_req(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        run_frames(3, 1'b1);

        // Random requests, with req_valid dropped after each accept.
        for (int i = 0; i < 4; i++)
            add_req(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        run_frames(4, 1'b0);

        // IRQ pulse in the middle of a frame.
        add_req(1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        t0 = -1; first_irq = -1; irq_cnt = 0;
        fork
            run_frames(1, 1'b0);
            begin
                repeat (40) @(posedge clk);
                #1 irq = 1'b1;
                t0 = cyc;
                repeat (3) @(posedge clk);
                #1 irq = 1'b0;
            end
            begin
                repeat (80) begin
                    @(negedge clk);
                    if (irq_sync) begin
                        if (first_irq < 0) first_irq = cyc;
                        irq_cnt++;
                    end
                end
            end
        join
        check_eq("irq_delay", first_irq - t0, 2);
        check_eq("irq_length", irq_cnt, 3);

        // Fastest timing, with a loopback slave.
        set_mode(1'b1);
        loopback = 1'b1;
        for (int i = 0; i < 4; i++)
            add_req(1'($urandom), 7'($urandom), 8'($urandom), 8'h00, 8'h00);
        run_frames(4, 1'b1);
        loopback = 1'b0;
        set_mode(1'b0);

        // Reset asserted during bit 9 of a frame.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'($urandom); req_wdata = 8'($urandom);
        t = 0;
        while (!req_ready && t < 3000) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rises = 0; t = 0; prev = sclk;
        while (rises < 7 && t < 3000) begin
            @(negedge clk);
            if (sclk && !prev) rises++;
            prev = sclk;
            t++;
        end
        check_eq("reset_reach_bit9", rises, 7);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_scsn", scsn, 1);
        check_eq("midrst_sclk", sclk, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ready", req_ready, 1);
        rsp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check_eq("midrst_no_rsp", rsp_seen, 0);
        add_req(1'b1, 7'h7F, 8'hFF, 8'($urandom), 8'($urandom));
        run_frames(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
